mem_host_arbiter: RTL and testbench
===================================

Name: mem_host_arbiter

Overview:
- Shares the processor's single data-memory port between the processor and an external host requester (debug/loader).
- The host gets the port only while the processor is parked on a `wait` instruction (`wait_for_continue=1`).
- The block also sequences resumption by issuing the one-cycle `wait_continue_execution` pulse.
- Sits between `processor_staged` and the data RAM.

Parameters:
- ADDR_SIZE, 18, memory address width
- WORD_SIZE, 18, data word width
- TIMEOUT_CYCLES, 1024, host-request watchdog limit (used only with the optional feature; at most 65535)

Ports:
- clock  in  1  single system clock
- reset  in  1  synchronous, active-high reset
- proc_memory_write_enable  in  1  processor write strobe
- proc_memory_addr  in  ADDR_SIZE  processor address
- proc_memory_in  in  WORD_SIZE  processor write data
- wait_for_continue  in  1  processor is parked on `wait`
- wait_continue_execution  out  1  one-cycle resume pulse to the processor
- memory_write_enable  out  1  RAM write strobe (muxed)
- memory_addr  out  ADDR_SIZE  RAM address (muxed)
- memory_in  out  WORD_SIZE  RAM write data (muxed)
- memory_out  in  WORD_SIZE  RAM read data; synchronous, valid the cycle after the address; fanned to the processor unchanged
- host_req  in  1  host request; level signal, held until `host_ack`
- host_we  in  1  1 = write, 0 = read; qualified by `host_req`
- host_addr  in  ADDR_SIZE  host address
- host_wdata  in  WORD_SIZE  host write data
- host_resume  in  1  one-cycle pulse requesting processor resume
- host_ready  out  1  host owns the port (state HOST_IDLE)
- host_ack  out  1  one-cycle transaction-complete pulse
- host_rdata  out  WORD_SIZE  read data, valid with `host_ack`, held until the next ack
- host_err  out  1  valid with `host_ack`; 1 = timed out, no access performed

Behaviour:
- States (package enum):
  - PROC: memory port mux selects the processor.
  - HOST_IDLE, HOST_ACC, HOST_ACK: mux selects the host.
  - RESUME, DRAIN: mux selects the processor.
- Reset: state PROC; all outputs 0, including `host_rdata`; pending-resume flag cleared.
  - Reset mid-transaction aborts it with no `host_ack`.
  - RAM writes are only those registered before reset.
- PROC -> HOST_IDLE when `wait_for_continue=1`.
  - A `host_req` raised in PROC stays pending, with no ack, until HOST_IDLE is entered.
- HOST_IDLE:
  - If `host_req=1`: drive `memory_addr=host_addr`. For writes, also drive `memory_write_enable=1` and `memory_in=host_wdata` this cycle. Go to HOST_ACC.
  - Else if resume is pending: go to RESUME.
- HOST_ACC:
  - Port driven idle (`memory_write_enable=0`).
  - Capture `memory_out` into `host_rdata` on reads; write data is ignored.
  - Go to HOST_ACK.
- HOST_ACK:
  - `host_ack=1` for one cycle, `host_err=0`, then HOST_IDLE.
  - Read latency from accept to ack is 2 cycles.
  - Sustained throughput with `host_req` held high is 1 transaction per 3 cycles.
- `host_resume` is latched into a pending flag in any state except RESUME/DRAIN. It is served in HOST_IDLE only when `host_req=0`.
  - If `host_req` and resume coincide, the request is served first.
- RESUME:
  - `wait_continue_execution=1` for exactly one cycle; clears the pending flag.
  - Go to DRAIN.
- DRAIN:
  - Wait for `wait_for_continue=0`, then go to PROC.
  - Prevents immediate re-entry on a stale `wait_for_continue`.
- `host_ready=1` only in HOST_IDLE.
- Host inputs are ignored in every state except HOST_IDLE.
- The processor's write strobe is forced to 0 at the RAM whenever the host owns the port.

Optional Feature:
- Macro: MEM_HOST_ARB_TIMEOUT_EN.
- With the macro:
  - A 16-bit counter increments each cycle that `host_req=1` in PROC, DRAIN or RESUME; it clears otherwise.
  - On reaching TIMEOUT_CYCLES: `host_ack=1` and `host_err=1` for one cycle, no memory access, `host_rdata` unchanged, counter cleared.
  - The host must drop `host_req` on ack.
- Without the macro: no counter; `host_err` is tied to 0; a request in PROC waits indefinitely.

Decomposition:
- Package `mem_host_arb_pkg`: state enum `arb_state_t` (PROC, HOST_IDLE, HOST_ACC, HOST_ACK, RESUME, DRAIN) and a localparam for counter width (16).
- The port mux stays inline.
- One sub-module is natural: `arb_timeout_counter` (clear/enable/expire), instantiated only under the macro.

Test Plan:
- Reset, then `wait_for_continue=1` -> `host_ready=1` next cycle; all outputs 0 during reset.
- In HOST_IDLE, host write addr 0x00010 data 0x3FFFF, then read addr 0x00010 -> RAM written once; read `host_ack` 2 cycles after accept; `host_rdata=0x3FFFF`; `host_err=0`.
- `host_req` (read) and `host_resume` in the same cycle -> read acked first; `wait_continue_execution` pulses once, 1 cycle after returning to HOST_IDLE; DRAIN until `wait_for_continue=0`, then PROC.
- `host_req` asserted while processor running, processor reaches `wait` after 50 cycles -> no ack before HOST_IDLE; transaction completes afterwards; processor write strobe never reaches RAM in host states.
- Reset asserted in HOST_ACC -> no `host_ack`; state PROC next cycle; `host_rdata=0`.
- MEM_HOST_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, `host_req` held while processor running -> `host_ack=1` and `host_err=1` on the 8th cycle; no RAM write.

Source files
------------

// File: rtl/mem_host_arb_pkg.sv
// ============================================================================
//  Module   : mem_host_arb_pkg
//  Brief    : Shared types and constants for the processor/host memory arbiter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package mem_host_arb_pkg;

    typedef enum logic [2:0] {
        PROC      = 3'd0,
        HOST_IDLE = 3'd1,
        HOST_ACC  = 3'd2,
        HOST_ACK  = 3'd3,
        RESUME    = 3'd4,
        DRAIN     = 3'd5
    } arb_state_t;

    localparam int c_tmo_cnt_width = 16;

endpackage

`default_nettype wire

// File: rtl/arb_timeout_counter.sv
// ============================================================================
//  Module   : arb_timeout_counter
//  Brief    : Watchdog counting enabled cycles; expires on the LIMIT-th one.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module arb_timeout_counter #(
    parameter int WIDTH = 16,
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_enable,
    output logic o_expire
);

    localparam logic [WIDTH-1:0] c_last = WIDTH'(LIMIT - 1);
    localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    assign o_expire = i_enable && (r_count == c_last);

    // Any gap in the enable restarts the count; expiry also restarts it.
    always_ff @(posedge clk) begin
        if (rst || !i_enable || o_expire) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_one;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_host_arbiter.sv
// ============================================================================
//  Module   : mem_host_arbiter
//  Brief    : Shares the data-memory port between processor and host while the
//             processor is parked on `wait`; sequences the resume pulse.
//             Optional host-request watchdog: define MEM_HOST_ARB_TIMEOUT_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mem_host_arbiter #(
    parameter int ADDR_SIZE      = 18,
    parameter int WORD_SIZE      = 18,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 proc_memory_write_enable,
    input  logic [ADDR_SIZE-1:0] proc_memory_addr,
    input  logic [WORD_SIZE-1:0] proc_memory_in,
    input  logic                 wait_for_continue,
    output logic                 wait_continue_execution,
    output logic                 memory_write_enable,
    output logic [ADDR_SIZE-1:0] memory_addr,
    output logic [WORD_SIZE-1:0] memory_in,
    input  logic [WORD_SIZE-1:0] memory_out,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [ADDR_SIZE-1:0] host_addr,
    input  logic [WORD_SIZE-1:0] host_wdata,
    input  logic                 host_resume,
    output logic                 host_ready,
    output logic                 host_ack,
    output logic [WORD_SIZE-1:0] host_rdata,
    output logic                 host_err
);

    import mem_host_arb_pkg::*;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << c_tmo_cnt_width) - 1) begin : g_bad_timeout
        $error("mem_host_arbiter: TIMEOUT_CYCLES out of range");
    end

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic                 r_resume_pend;
    logic                 r_host_we;
    logic [WORD_SIZE-1:0] r_host_rdata;
    logic                 w_accept;
    logic                 w_host_owns;
    logic                 w_host_write;
    logic                 w_tmo_expire;

    assign w_accept     = (r_state == HOST_IDLE) && host_req;
    assign w_host_write = w_accept && host_we;
    assign w_host_owns  = (r_state == HOST_IDLE) || (r_state == HOST_ACC) ||
                          (r_state == HOST_ACK);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            PROC:      if (wait_for_continue) w_state_nxt = HOST_IDLE;
            HOST_IDLE: begin
                if (host_req) begin
                    w_state_nxt = HOST_ACC;
                end else if (r_resume_pend) begin
                    w_state_nxt = RESUME;
                end
            end
            HOST_ACC:  w_state_nxt = HOST_ACK;
            HOST_ACK:  w_state_nxt = HOST_IDLE;
            RESUME:    w_state_nxt = DRAIN;
            // Hold off until the processor has actually left `wait`.
            DRAIN:     if (!wait_for_continue) w_state_nxt = PROC;
            default:   w_state_nxt = PROC;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= PROC;
            r_resume_pend <= 1'b0;
            r_host_we     <= 1'b0;
            r_host_rdata  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == RESUME) begin
                r_resume_pend <= 1'b0;
            end else if (host_resume && r_state != DRAIN) begin
                r_resume_pend <= 1'b1;
            end
            if (w_accept) begin
                r_host_we <= host_we;
            end
            // RAM read data arrives the cycle after the accepted address.
            if (r_state == HOST_ACC && !r_host_we) begin
                r_host_rdata <= memory_out;
            end
        end
    end

`ifdef MEM_HOST_ARB_TIMEOUT_EN
    logic w_tmo_enable;

    assign w_tmo_enable = !reset && host_req &&
                          (r_state == PROC || r_state == DRAIN || r_state == RESUME);

    arb_timeout_counter #(
        .WIDTH (c_tmo_cnt_width),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk      (clock),
        .rst      (reset),
        .i_enable (w_tmo_enable),
        .o_expire (w_tmo_expire)
    );
`else
    assign w_tmo_expire = 1'b0;
`endif

    // Outputs are forced quiet while reset is held.
    always_comb begin
        memory_write_enable = 1'b0;
        memory_addr         = '0;
        memory_in           = '0;
        if (!reset) begin
            if (w_host_owns) begin
                memory_write_enable = w_host_write;
                memory_addr         = w_accept ? host_addr : '0;
                memory_in           = w_host_write ? host_wdata : '0;
            end else begin
                memory_write_enable = proc_memory_write_enable;
                memory_addr         = proc_memory_addr;
                memory_in           = proc_memory_in;
            end
        end
    end

    assign wait_continue_execution = !reset && (r_state == RESUME);
    assign host_ready              = !reset && (r_state == HOST_IDLE);
    assign host_ack                = !reset && ((r_state == HOST_ACK) || w_tmo_expire);
    assign host_err                = !reset && w_tmo_expire;
    assign host_rdata              = reset ? '0 : r_host_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_host_arbiter.sv
// ============================================================================
//  Module   : tb_mem_host_arbiter
//  Brief    : Randomized self-checking bench for mem_host_arbiter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_host_arbiter;

    localparam int AW  = 18;
    localparam int DW  = 18;
    localparam int TMO = 8;
`ifdef MEM_HOST_ARB_TIMEOUT_EN
    localparam int HOLD = 5;
`else
    localparam int HOLD = 50;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          proc_memory_write_enable = 1'b0;
    logic [AW-1:0] proc_memory_addr = '0;
    logic [DW-1:0] proc_memory_in = '0;
    logic          wait_for_continue = 1'b0;
    logic          wait_continue_execution;
    logic          memory_write_enable;
    logic [AW-1:0] memory_addr;
    logic [DW-1:0] memory_in;
    logic [DW-1:0] memory_out = '0;
    logic          host_req = 1'b0;
    logic          host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_resume = 1'b0;
    logic          host_ready;
    logic          host_ack;
    logic [DW-1:0] host_rdata;
    logic          host_err;

    mem_host_arbiter #(
        .ADDR_SIZE      (AW),
        .WORD_SIZE      (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock                    (clock),
        .reset                    (reset),
        .proc_memory_write_enable (proc_memory_write_enable),
        .proc_memory_addr         (proc_memory_addr),
        .proc_memory_in           (proc_memory_in),
        .wait_for_continue        (wait_for_continue),
        .wait_continue_execution  (wait_continue_execution),
        .memory_write_enable      (memory_write_enable),
        .memory_addr              (memory_addr),
        .memory_in                (memory_in),
        .memory_out               (memory_out),
        .host_req                 (host_req),
        .host_we                  (host_we),
        .host_addr                (host_addr),
        .host_wdata               (host_wdata),
        .host_resume              (host_resume),
        .host_ready               (host_ready),
        .host_ack                 (host_ack),
        .host_rdata               (host_rdata),
        .host_err                 (host_err)
    );

    always #5 clock = ~clock;

    // Synchronous RAM; host uses 0..255, processor uses 512..1023.
    logic [DW-1:0] ram [0:1023];
    int            host_wr_cnt = 0;

    always @(posedge clock) begin
        if (memory_write_enable) begin
            ram[memory_addr[9:0]] <= memory_in;
            if (memory_addr < 256) host_wr_cnt <= host_wr_cnt + 1;
        end
        memory_out <= ram[memory_addr[9:0]];
    end

    logic [DW-1:0] ref_mem [0:255];
    bit            written [0:255];
    logic [DW-1:0] exp_rdata = '0;
    int            exp_wr = 0;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_proc();
        proc_memory_write_enable = 1'($urandom_range(0, 1));
        proc_memory_addr         = AW'(512 + $urandom_range(0, 511));
        proc_memory_in           = DW'($urandom);
    endtask

    // One host transaction started from HOST_IDLE: accept, access, ack.
    task automatic host_txn(input logic we, input logic [7:0] a,
                            input logic [DW-1:0] d, input logic resume);
        host_req = 1'b1; host_we = we; host_addr = {10'b0, a};
        host_wdata = d; host_resume = resume; drive_proc();
        @(negedge clock);
        chk("accept_ready", host_ready, 1);
        chk("accept_we", memory_write_enable, we);
        chk("accept_addr", memory_addr, a);
        if (we) chk("accept_wdata", memory_in, d);
        chk("accept_ack", host_ack, 0);
        next_cycle();
        host_resume = 1'b0; host_we = ~we; host_wdata = DW'($urandom); drive_proc();
        @(negedge clock);
        chk("acc_we", memory_write_enable, 0);
        chk("acc_ack", host_ack, 0);
        chk("acc_ready", host_ready, 0);
        next_cycle();
        drive_proc();
        if (we) begin
            ref_mem[a] = d; written[a] = 1'b1; exp_wr++;
        end else begin
            exp_rdata = ref_mem[a];
        end
        @(negedge clock);
        chk("ack", host_ack, 1);
        chk("ack_err", host_err, 0);
        chk("ack_we", memory_write_enable, 0);
        chk("ack_rdata", host_rdata, exp_rdata);
        next_cycle();
        host_req = 1'b0; host_we = 1'b0;
    endtask

    initial begin
        logic [7:0] a;
        logic       we;
        int         gap;

        // Reset with busy inputs: every output must stay 0.
        wait_for_continue = 1'b1; host_req = 1'b1; host_we = 1'b1;
        host_addr = 18'h00010; host_wdata = 18'h3FFFF; host_resume = 1'b1;
        proc_memory_write_enable = 1'b1; proc_memory_addr = 18'h00300;
        proc_memory_in = 18'h12345;
        next_cycle();
        next_cycle();
        @(negedge clock);
        chk("rst_wce", wait_continue_execution, 0);
        chk("rst_we", memory_write_enable, 0);
        chk("rst_addr", memory_addr, 0);
        chk("rst_in", memory_in, 0);
        chk("rst_ready", host_ready, 0);
        chk("rst_ack", host_ack, 0);
        chk("rst_rdata", host_rdata, 0);
        chk("rst_err", host_err, 0);
        next_cycle();

        reset = 1'b0; wait_for_continue = 1'b0; host_req = 1'b0;
        host_resume = 1'b0; host_we = 1'b0; drive_proc();
        @(negedge clock);
        chk("proc_ready", host_ready, 0);
        chk("proc_we", memory_write_enable, proc_memory_write_enable);
        chk("proc_addr", memory_addr, proc_memory_addr);
        chk("proc_in", memory_in, proc_memory_in);
        next_cycle();
        wait_for_continue = 1'b1; drive_proc();
        @(negedge clock);
        chk("wfc_same_cycle_ready", host_ready, 0);
        next_cycle();

        // Directed write 0x3FFFF to 0x10, then read it back.
        host_txn(1'b1, 8'h10, 18'h3FFFF, 1'b0);
        host_txn(1'b0, 8'h10, 18'h0, 1'b0);
        chk("directed_rdata", host_rdata, 18'h3FFFF);

        for (int i = 0; i < 40; i++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                drive_proc();
                @(negedge clock);
                chk("idle_ready", host_ready, 1);
                chk("idle_we", memory_write_enable, 0);
                chk("idle_rdata_hold", host_rdata, exp_rdata);
                next_cycle();
            end
            a  = 8'($urandom_range(0, 255));
            we = !written[a] || ($urandom_range(0, 1) == 1);
            host_txn(we, a, DW'($urandom), 1'b0);
        end

        // Read and resume together: read first, then one resume pulse.
        host_txn(1'b0, 8'h10, 18'h0, 1'b1);
        drive_proc();
        @(negedge clock);
        chk("post_ack_ready", host_ready, 1);
        chk("post_ack_wce", wait_continue_execution, 0);
        next_cycle();
        drive_proc();
        @(negedge clock);
        chk("resume_wce", wait_continue_execution, 1);
        chk("resume_ready", host_ready, 0);
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            drive_proc();
            @(negedge clock);
            chk("drain_wce", wait_continue_execution, 0);
            chk("drain_ready", host_ready, 0);
            chk("drain_we", memory_write_enable, proc_memory_write_enable);
            next_cycle();
        end
        wait_for_continue = 1'b0; drive_proc();
        @(negedge clock);
        chk("drain_exit_wce", wait_continue_execution, 0);
        next_cycle();

        // Host request raised while the processor runs.
        host_req = 1'b1; host_we = 1'b0; host_addr = 18'h00010;
        for (int k = 0; k < HOLD; k++) begin
            drive_proc();
            @(negedge clock);
            chk("pend_ack", host_ack, 0);
            chk("pend_ready", host_ready, 0);
            chk("pend_we", memory_write_enable, proc_memory_write_enable);
            chk("pend_addr", memory_addr, proc_memory_addr);
            next_cycle();
        end
        wait_for_continue = 1'b1; drive_proc();
        @(negedge clock);
        chk("pend_last_proc_ack", host_ack, 0);
        next_cycle();
        host_txn(1'b0, 8'h10, 18'h0, 1'b0);

        // Reset during HOST_ACC aborts without an ack.
        host_req = 1'b1; host_we = 1'b0; host_addr = 18'h00010;
        next_cycle();
        reset = 1'b1; host_req = 1'b0;
        @(negedge clock);
        chk("abort_rst_ack", host_ack, 0);
        chk("abort_rst_rdata", host_rdata, 0);
        next_cycle();
        reset = 1'b0; wait_for_continue = 1'b0; drive_proc();
        exp_rdata = '0;
        @(negedge clock);
        chk("abort_ack", host_ack, 0);
        chk("abort_ready", host_ready, 0);
        chk("abort_rdata", host_rdata, 0);
        chk("abort_we", memory_write_enable, proc_memory_write_enable);
        next_cycle();
        drive_proc();
        @(negedge clock);
        chk("abort_ack2", host_ack, 0);
        next_cycle();

`ifdef MEM_HOST_ARB_TIMEOUT_EN
        // Watchdog: request held in PROC expires on its TMO-th cycle.
        host_req = 1'b1; host_we = 1'b1; host_addr = 18'h00020;
        host_wdata = 18'h2AAAA; proc_memory_write_enable = 1'b0;
        for (int k = 1; k <= TMO; k++) begin
            @(negedge clock);
            chk("tmo_ack", host_ack, (k == TMO));
            chk("tmo_err", host_err, (k == TMO));
            chk("tmo_we", memory_write_enable, 0);
            chk("tmo_rdata", host_rdata, exp_rdata);
            next_cycle();
        end
        host_req = 1'b0;
        @(negedge clock);
        chk("tmo_after_ack", host_ack, 0);
        next_cycle();
`endif

        chk("host_ram_writes", host_wr_cnt, exp_wr);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
